// File: rtl/jtag_host_driver.sv
// JTAG initiator: turns TAP_RESET / SHIFT_IR / SHIFT_DR / IDLE commands into
// TCK/TMS/TDI waveforms and returns the captured TDO bits as one response.
module jtag_host_driver #(
  parameter int unsigned ClkDiv = 4,
  parameter int unsigned MaxLen = 64,
  parameter int unsigned LenW   = $clog2(MaxLen + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [LenW-1:0]   cmd_len_i,
  input  logic [MaxLen-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_data_o,
  output logic              trst_no,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i
);

  localparam int unsigned DivW  = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int unsigned IdxW  = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  // Room for the longest preamble + shift + postamble, plus one.
  localparam int unsigned StepW = $clog2(MaxLen + 9);

  typedef enum logic [1:0] {
    OP_TAP_RESET = 2'd0,
    OP_SHIFT_IR  = 2'd1,
    OP_SHIFT_DR  = 2'd2,
    OP_IDLE      = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_POST  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  state_e            r_state;
  op_e               r_op;
  logic [MaxLen-1:0] r_data;
  logic [LenW-1:0]   r_len;
  logic [StepW-1:0]  r_idx;
  logic [IdxW-1:0]   r_bit;
  logic [DivW-1:0]   r_div;
  logic              r_phase;
  logic              r_run;
  logic              r_tck;
  logic              r_tms;
  logic              r_tdi;
  logic              r_trst;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [MaxLen-1:0] r_rsp_data;

  op_e               w_cmd_op;
  logic [LenW-1:0]   w_eff_len;
  logic [StepW-1:0]  w_pre_n;
  logic [StepW-1:0]  w_shift_n;
  logic [StepW-1:0]  w_post_n;
  logic [StepW-1:0]  w_shift_end;
  logic [StepW-1:0]  w_total;
  logic [StepW-1:0]  w_rel_shift;
  logic [StepW-1:0]  w_rel_post;
  logic              w_has_step;
  logic              w_is_shift_op;
  logic              w_div_last;
  state_e            w_step_state;
  logic              w_step_tms;
  logic              w_step_tdi;
  logic              w_step_trst;
  logic [IdxW-1:0]   w_step_bit;

  assign w_cmd_op      = op_e'(cmd_op_i);
  assign w_is_shift_op = (r_op == OP_SHIFT_IR) || (r_op == OP_SHIFT_DR);
  assign w_div_last    = (r_div == DivW'(ClkDiv - 1));
  assign w_shift_end   = w_pre_n + w_shift_n;
  assign w_total       = w_shift_end + w_post_n;
  assign w_has_step    = (r_idx < w_total);
  assign w_rel_shift   = r_idx - w_pre_n;
  assign w_rel_post    = r_idx - w_shift_end;

  // Effective length: clamp to MaxLen, zero-length shifts become one bit.
  always_comb begin
    w_eff_len = cmd_len_i;
    if (cmd_len_i > LenW'(MaxLen)) begin
      w_eff_len = LenW'(MaxLen);
    end else if ((cmd_len_i == '0) &&
                 ((w_cmd_op == OP_SHIFT_IR) || (w_cmd_op == OP_SHIFT_DR))) begin
      w_eff_len = LenW'(1);
    end
  end

  // Step counts of each phase for the latched command.
  always_comb begin
    w_pre_n   = '0;
    w_shift_n = StepW'(r_len);
    w_post_n  = '0;
    case (r_op)
      OP_TAP_RESET: begin
        w_pre_n   = StepW'(6);
        w_shift_n = '0;
        w_post_n  = StepW'(1);
      end
      OP_SHIFT_IR: begin
        w_pre_n  = StepW'(4);
        w_post_n = StepW'(2);
      end
      OP_SHIFT_DR: begin
        w_pre_n  = StepW'(3);
        w_post_n = StepW'(2);
      end
      default: ;
    endcase
  end

  // Pin values for the step with global index r_idx.
  always_comb begin
    w_step_state = ST_POST;
    w_step_tms   = 1'b0;
    w_step_tdi   = 1'b0;
    w_step_trst  = 1'b1;
    w_step_bit   = IdxW'(w_rel_shift);
    if (r_idx < w_pre_n) begin
      w_step_state = ST_PRE;
      case (r_op)
        OP_TAP_RESET: begin
          w_step_tms  = 1'b1;
          w_step_trst = (r_idx != '0);
        end
        OP_SHIFT_IR: w_step_tms = (r_idx < StepW'(2));
        OP_SHIFT_DR: w_step_tms = (r_idx == '0);
        default: ;
      endcase
    end else if (r_idx < w_shift_end) begin
      w_step_state = ST_SHIFT;
      if (w_is_shift_op) begin
        w_step_tdi = r_data[w_step_bit];
        w_step_tms = (w_rel_shift == (w_shift_n - StepW'(1)));
      end
    end else begin
      w_step_tms = w_is_shift_op && (w_rel_post == '0);
    end
  end

  // Command FSM and TCK step engine; the next step is launched on the same
  // edge the previous one ends so every TCK half-period is exactly ClkDiv.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_IDLE;
      r_data      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_bit       <= '0;
      r_div       <= '0;
      r_phase     <= 1'b0;
      r_run       <= 1'b0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_trst      <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_trst      <= 1'b1;
          r_cmd_ready <= !r_rsp_valid;
          if (cmd_valid_i && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_op        <= w_cmd_op;
            r_data      <= cmd_data_i;
            r_len       <= w_eff_len;
            r_idx       <= '0;
            r_run       <= 1'b0;
            r_rsp_data  <= '0;
            r_state     <= ST_PRE;
          end
        end
        ST_PRE, ST_SHIFT, ST_POST: begin
          if (!r_run || (r_phase && w_div_last)) begin
            r_tck   <= 1'b0;
            r_div   <= '0;
            r_phase <= 1'b0;
            if (w_has_step) begin
              r_run   <= 1'b1;
              r_state <= w_step_state;
              r_tms   <= w_step_tms;
              r_tdi   <= w_step_tdi;
              r_trst  <= w_step_trst;
              r_bit   <= w_step_bit;
              r_idx   <= r_idx + StepW'(1);
            end else begin
              r_run       <= 1'b0;
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
            end
          end else if (w_div_last) begin
            r_div   <= '0;
            r_tck   <= 1'b1;
            r_phase <= 1'b1;
            if ((r_state == ST_SHIFT) && w_is_shift_op) begin
              r_rsp_data[r_bit] <= tdo_i;
            end
          end else begin
            r_div <= r_div + DivW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign trst_no     = r_trst;
  assign tck_o       = r_tck;
  assign tms_o       = r_tms;
  assign tdi_o       = r_tdi;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Directed bench for jtag_host_driver with a behavioural TAP on the pins.
module tb_jtag_host_driver;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op = 2'd0;
  logic [6:0]  cmd_len = 7'd0;
  logic [63:0] cmd_data = 64'd0;
  logic        rsp_valid_o;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data_o;
  logic        trst_no, tck_o, tms_o, tdi_o;
  logic        tdo = 1'b0;

  int checks = 0;
  int failures = 0;

  int          g_pulses, g_trst_low, g_hi_min, g_hi_max, g_lo_min, g_lo_max, g_lat;
  logic [127:0] g_tms, g_tdi;
  logic [63:0] g_rsp;

  jtag_host_driver dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_o),
    .trst_no(trst_no), .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo)
  );

  always #5 clk = ~clk;

  // TAP state model: IR captures 0x01, DR captures IDCODE 0xDEADBEEF.
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PAUSEDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                 SHIR = 11, EX1IR = 12, PAUSEIR = 13, EX2IR = 14, UPIR = 15;

  int          tap_state = TLR;
  logic [63:0] tap_sr = 64'd0;

  function automatic int tap_next(input int s, input logic t);
    case (s)
      TLR:     return t ? TLR   : RTI;
      RTI:     return t ? SELDR : RTI;
      SELDR:   return t ? SELIR : CAPDR;
      CAPDR:   return t ? EX1DR : SHDR;
      SHDR:    return t ? EX1DR : SHDR;
      EX1DR:   return t ? UPDR  : PAUSEDR;
      PAUSEDR: return t ? EX2DR : PAUSEDR;
      EX2DR:   return t ? UPDR  : SHDR;
      UPDR:    return t ? SELDR : RTI;
      SELIR:   return t ? TLR   : CAPIR;
      CAPIR:   return t ? EX1IR : SHIR;
      SHIR:    return t ? EX1IR : SHIR;
      EX1IR:   return t ? UPIR  : PAUSEIR;
      PAUSEIR: return t ? EX2IR : PAUSEIR;
      EX2IR:   return t ? UPIR  : SHIR;
      UPIR:    return t ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge tck_o or negedge trst_no) begin
    if (!trst_no) begin
      tap_state <= TLR;
    end else begin
      if (tap_state == SHDR || tap_state == SHIR) tap_sr <= {tdi_o, tap_sr[63:1]};
      else if (tap_state == CAPDR) tap_sr <= 64'h0000_0000_DEAD_BEEF;
      else if (tap_state == CAPIR) tap_sr <= 64'h1;
      tap_state <= tap_next(tap_state, tms_o);
    end
  end

  always @(negedge tck_o) begin
    tdo <= (tap_state == SHDR || tap_state == SHIR) ? tap_sr[0] : 1'b0;
  end

  // Issue one command and record the pin activity until rsp_valid_o rises.
  task automatic run_cmd(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
    int   waitc;
    int   run;
    bit   run_valid;
    logic prev_tck;
    g_pulses = 0; g_trst_low = 0; g_lat = 0;
    g_hi_min = 1000; g_hi_max = 0; g_lo_min = 1000; g_lo_max = 0;
    g_tms = '0; g_tdi = '0; g_rsp = '0;
    waitc = 0;
    while (cmd_ready_o !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (cmd_ready_o !== 1'b1) begin
      checks++; failures++;
      $display("FAIL cmd_ready_wait got=%b exp=1", cmd_ready_o);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    prev_tck = 1'b0; run = 0; run_valid = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (trst_no === 1'b0) g_trst_low++;
      if (tck_o !== prev_tck) begin
        if (run_valid) begin
          if (prev_tck) begin
            if (run < g_hi_min) g_hi_min = run;
            if (run > g_hi_max) g_hi_max = run;
          end else begin
            if (run < g_lo_min) g_lo_min = run;
            if (run > g_lo_max) g_lo_max = run;
          end
        end
        run_valid = 1'b1;
        run = 1;
        if (tck_o === 1'b1) begin
          g_pulses++;
          g_tms = {g_tms[126:0], tms_o};
          g_tdi = {g_tdi[126:0], tdi_o};
        end
        prev_tck = tck_o;
      end else begin
        run++;
      end
      if (rsp_valid_o === 1'b1) begin
        g_lat = k;
        g_rsp = rsp_data_o;
        break;
      end
    end
    if (g_lat == 0) begin
      checks++; failures++;
      $display("FAIL rsp_timeout got=rsp_valid %b exp=1", rsp_valid_o);
    end
  endtask

  task automatic consume_rsp;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tck_o !== 1'b0) begin failures++; $display("FAIL rst_tck got=%b exp=0", tck_o); end
    checks++; if (tms_o !== 1'b1) begin failures++; $display("FAIL rst_tms got=%b exp=1", tms_o); end
    checks++; if (tdi_o !== 1'b0) begin failures++; $display("FAIL rst_tdi got=%b exp=0", tdi_o); end
    checks++; if (trst_no !== 1'b0) begin failures++; $display("FAIL rst_trst got=%b exp=0", trst_no); end
    checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid_o); end
    checks++; if (rsp_data_o !== 64'd0) begin failures++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data_o); end
    rst_ni = 1'b1;
    @(negedge clk);
    checks++; if (trst_no !== 1'b1) begin failures++; $display("FAIL rel_trst got=%b exp=1", trst_no); end
    checks++; if (tms_o !== 1'b1) begin failures++; $display("FAIL rel_tms got=%b exp=1", tms_o); end
    @(negedge clk);
    checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL rel_cmd_ready got=%b exp=1", cmd_ready_o); end
  endtask

  task automatic test_tap_reset;
    run_cmd(2'd0, 7'd0, 64'd0);
    checks++; if (g_trst_low != 8) begin failures++; $display("FAIL trst_low_cycles got=%0d exp=8", g_trst_low); end
    checks++; if (g_pulses != 7) begin failures++; $display("FAIL reset_pulses got=%0d exp=7", g_pulses); end
    checks++; if (g_tms[6:0] !== 7'b1111110) begin failures++; $display("FAIL reset_tms_seq got=%b exp=1111110", g_tms[6:0]); end
    checks++; if (g_rsp !== 64'd0) begin failures++; $display("FAIL reset_rsp got=%h exp=0", g_rsp); end
    checks++; if (g_hi_min != 4 || g_hi_max != 4) begin failures++; $display("FAIL tck_high got=%0d..%0d exp=4", g_hi_min, g_hi_max); end
    checks++; if (g_lo_min != 4 || g_lo_max != 4) begin failures++; $display("FAIL tck_low got=%0d..%0d exp=4", g_lo_min, g_lo_max); end
    consume_rsp();
    checks++; if (tap_state != RTI) begin failures++; $display("FAIL reset_tap_state got=%0d exp=%0d", tap_state, RTI); end
  endtask

  task automatic test_shift_ir;
    run_cmd(2'd1, 7'd5, 64'h01);
    checks++; if (g_pulses != 11) begin failures++; $display("FAIL ir_pulses got=%0d exp=11", g_pulses); end
    checks++; if (g_tms[10:0] !== 11'b11000000110) begin failures++; $display("FAIL ir_tms_seq got=%b exp=11000000110", g_tms[10:0]); end
    checks++; if (g_tdi[6:2] !== 5'b10000) begin failures++; $display("FAIL ir_tdi_seq got=%b exp=10000", g_tdi[6:2]); end
    checks++; if (g_rsp !== 64'h1) begin failures++; $display("FAIL ir_rsp got=%h exp=1", g_rsp); end
    consume_rsp();
    checks++; if (tap_state != RTI) begin failures++; $display("FAIL ir_tap_state got=%0d exp=%0d", tap_state, RTI); end
  endtask

  task automatic test_shift_dr_idcode;
    run_cmd(2'd2, 7'd32, 64'd0);
    checks++; if (g_pulses != 37) begin failures++; $display("FAIL dr_pulses got=%0d exp=37", g_pulses); end
    checks++; if (g_rsp !== 64'h0000_0000_DEAD_BEEF) begin failures++; $display("FAIL dr_idcode got=%h exp=00000000deadbeef", g_rsp); end
    consume_rsp();
  endtask

  task automatic test_backpressure;
    bit data_bad, ready_bad, valid_bad, tck_bad;
    data_bad = 0; ready_bad = 0; valid_bad = 0; tck_bad = 0;
    run_cmd(2'd2, 7'd8, 64'd0);
    checks++; if (g_rsp !== 64'hEF) begin failures++; $display("FAIL bp_rsp got=%h exp=ef", g_rsp); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin cmd_valid = 1'b1; cmd_op = 2'd3; cmd_len = 7'd5; end
      if (i == 4) cmd_valid = 1'b0;
      @(negedge clk);
      if (rsp_data_o !== 64'hEF) data_bad = 1;
      if (cmd_ready_o !== 1'b0) ready_bad = 1;
      if (rsp_valid_o !== 1'b1) valid_bad = 1;
    end
    checks++; if (data_bad) begin failures++; $display("FAIL bp_data_stable got=unstable exp=ef"); end
    checks++; if (ready_bad) begin failures++; $display("FAIL bp_cmd_ready got=1 exp=0"); end
    checks++; if (valid_bad) begin failures++; $display("FAIL bp_rsp_valid got=0 exp=1"); end
    consume_rsp();
    valid_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tck_o !== 1'b0) tck_bad = 1;
      if (rsp_valid_o !== 1'b0) valid_bad = 1;
    end
    checks++; if (tck_bad) begin failures++; $display("FAIL bp_pulse_accepted got=tck_activity exp=none"); end
    checks++; if (valid_bad) begin failures++; $display("FAIL bp_extra_rsp got=rsp_valid exp=0"); end
    checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", cmd_ready_o); end
  endtask

  task automatic test_len_edges;
    run_cmd(2'd2, 7'd0, 64'd0);
    checks++; if (g_pulses != 6) begin failures++; $display("FAIL len0_pulses got=%0d exp=6", g_pulses); end
    checks++; if (g_rsp !== 64'h1) begin failures++; $display("FAIL len0_rsp got=%h exp=1", g_rsp); end
    consume_rsp();
    run_cmd(2'd2, 7'd69, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if (g_pulses != 69) begin failures++; $display("FAIL clamp_pulses got=%0d exp=69", g_pulses); end
    checks++; if (g_rsp !== 64'h0000_0000_DEAD_BEEF) begin failures++; $display("FAIL clamp_rsp got=%h exp=00000000deadbeef", g_rsp); end
    consume_rsp();
    run_cmd(2'd3, 7'd0, 64'd0);
    checks++; if (g_lat != 2) begin failures++; $display("FAIL idle0_latency got=%0d exp=2", g_lat); end
    checks++; if (g_pulses != 0) begin failures++; $display("FAIL idle0_pulses got=%0d exp=0", g_pulses); end
    consume_rsp();
    run_cmd(2'd3, 7'd3, 64'hFF);
    checks++; if (g_pulses != 3) begin failures++; $display("FAIL idle3_pulses got=%0d exp=3", g_pulses); end
    checks++; if (g_tms[2:0] !== 3'b000) begin failures++; $display("FAIL idle3_tms got=%b exp=000", g_tms[2:0]); end
    checks++; if (g_rsp !== 64'd0) begin failures++; $display("FAIL idle3_rsp got=%h exp=0", g_rsp); end
    consume_rsp();
    checks++; if (tap_state != RTI) begin failures++; $display("FAIL idle3_tap_state got=%0d exp=%0d", tap_state, RTI); end
  endtask

  task automatic test_reset_mid_shift;
    int   rises;
    int   waitc;
    logic prev_tck;
    waitc = 0;
    while (cmd_ready_o !== 1'b1 && waitc < 100) begin @(negedge clk); waitc++; end
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 7'd32; cmd_data = 64'd0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    rises = 0; prev_tck = 1'b0;
    for (int k = 0; k < 400 && rises < 5; k++) begin
      @(negedge clk);
      if (tck_o === 1'b1 && prev_tck === 1'b0) rises++;
      prev_tck = tck_o;
    end
    checks++; if (rises != 5) begin failures++; $display("FAIL mid_reach_shift got=%0d exp=5", rises); end
    @(negedge clk);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (tck_o !== 1'b0) begin failures++; $display("FAIL mid_tck got=%b exp=0", tck_o); end
    checks++; if (tms_o !== 1'b1) begin failures++; $display("FAIL mid_tms got=%b exp=1", tms_o); end
    checks++; if (trst_no !== 1'b0) begin failures++; $display("FAIL mid_trst got=%b exp=0", trst_no); end
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL mid_rsp_valid got=%b exp=0", rsp_valid_o); end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    run_cmd(2'd0, 7'd0, 64'd0);
    checks++; if (g_pulses != 7) begin failures++; $display("FAIL post_rst_pulses got=%0d exp=7", g_pulses); end
    checks++; if (g_trst_low != 8) begin failures++; $display("FAIL post_rst_trst got=%0d exp=8", g_trst_low); end
    checks++; if (g_rsp !== 64'd0) begin failures++; $display("FAIL post_rst_rsp got=%h exp=0", g_rsp); end
    consume_rsp();
    checks++; if (tap_state != RTI) begin failures++; $display("FAIL post_rst_tap_state got=%0d exp=%0d", tap_state, RTI); end
  endtask

  initial begin
    test_reset();
    test_tap_reset();
    test_shift_ir();
    test_shift_dr_idcode();
    test_backpressure();
    test_len_edges();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_host_driver.md
Name: jtag_host_driver

Overview:
- Simulation-side JTAG initiator that drives the debug TAP of verilator_multicore (trst_ni/tms_i/tck_i/td_i/td_o) from a simple command/response interface.
- Lets benches and DPI shims issue TAP reset, IR shifts, DR shifts and idle clocks without bit-banging JTAG pins.
- Sits in top_verilator between a command source and the core's JTAG pins, in place of the currently undriven jtag_* nets.

Parameters:
- ClkDiv, 4: clk_i cycles per TCK half-period; legal range >=1.
- MaxLen, 64: maximum shift length in bits, and the width of the data buses.
- LenW, $clog2(MaxLen+1): width of cmd_len_i (derived).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  synchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_op_i  in  2  0=TAP_RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=IDLE.
- cmd_len_i  in  LenW  shift length (SHIFT_*) or TCK count (IDLE).
- cmd_data_i  in  MaxLen  TDI bits, LSB shifted first.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_data_o  out  MaxLen  captured TDO; bit i is the i-th shifted bit; bits >= len are 0.
- trst_no  out  1  TAP reset, active low.
- tck_o  out  1  TCK.
- tms_o  out  1  TMS.
- tdi_o  out  1  TDI.
- tdo_i  in  1  TDO from the TAP.

Behaviour:
- All flops reset synchronously when rst_ni=0. Reset values: tck_o=0, tms_o=1, tdi_o=0, trst_no=0, cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, FSM=IDLE.
- trst_no goes 1 in the first cycle after reset release. Reset asserted mid-command aborts immediately to the reset values; TAP state is then undefined until the next TAP_RESET.
- TCK step: each TAP step lasts 2*ClkDiv clk_i cycles.
  - At step start, tck_o=0 and tms_o/tdi_o are updated.
  - After ClkDiv cycles, tck_o goes 1. tdo_i is sampled in that same clk_i cycle.
  - After ClkDiv more cycles, tck_o goes 0 and the next step starts.
  - A divide counter (0..ClkDiv-1) plus a phase bit generates this timing.
- FSM states: IDLE, PRE, SHIFT, POST, RESP.
  - IDLE: cmd_ready_o=1 iff rsp_valid_o=0. On handshake, latch op, data and effective length; go PRE.
  - PRE (TMS preamble):
    - TAP_RESET: trst_no=0 for one step with TMS=1, then five TMS=1 steps with trst_no=1.
    - SHIFT_DR: TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR).
    - SHIFT_IR: TMS 1,1,0,0.
    - IDLE op: no preamble.
  - SHIFT:
    - SHIFT_*: len steps. tdi_o = data[i]. TMS=0 except the last step, which has TMS=1 (enters Exit1). Capture tdo_i into bit i.
    - IDLE op: len steps with TMS=0, TDI=0, nothing captured.
    - TAP_RESET: no SHIFT steps.
  - POST:
    - SHIFT_*: TMS 1,0 (Update, Run-Test/Idle).
    - TAP_RESET: TMS 0 (Run-Test/Idle).
    - IDLE op: no POST steps.
  - RESP: rsp_valid_o=1 with rsp_data_o held stable until rsp_ready_i=1. Then go to IDLE with rsp_valid_o=0 in the next cycle.
- Every command yields exactly one response. rsp_data_o=0 for TAP_RESET and IDLE.
- Effective length:
  - SHIFT_* with len=0 is treated as 1.
  - len > MaxLen is clamped to MaxLen.
  - IDLE with len=0 runs no steps and goes to RESP one cycle after acceptance.
- Between commands, tck_o=0 and tms_o holds 0 (the TAP parks in Run-Test/Idle). After reset, tms_o=1 until the first command.
- No new command is accepted while a response is pending. cmd_valid_i asserted during a busy state is ignored and does not need to stay stable.

Test Plan:
- TAP_RESET, ClkDiv=4:
  - trst_no low for exactly 8 cycles.
  - tms_o sequence over 7 steps is 1,1,1,1,1,1,0.
  - rsp_data_o=0.
  - Each TCK high and low period is 4 cycles.
- SHIFT_IR, len=5, data=0x01, TAP model returns capture 0x01:
  - TMS sequence 1,1,0,0,0,0,0,0,1,1,0.
  - TDI sequence during shift is 1,0,0,0,0.
  - rsp_data_o=0x01.
- SHIFT_DR, len=32, data=0, TDO model holding IDCODE 0xDEADBEEF: rsp_data_o=0x00000000DEADBEEF and bits 63:32 are 0.
- Response backpressure: hold rsp_ready_i=0 for 10 cycles after rsp_valid_o rises.
  - rsp_data_o stays stable throughout.
  - cmd_ready_o stays 0 throughout.
  - A cmd_valid_i pulse during this window is not accepted.
- Length edges:
  - SHIFT_DR with len=0 performs one shift step.
  - len=MaxLen+5 is clamped to 64 shift steps.
  - IDLE with len=0 gives rsp_valid_o 2 cycles after the accept cycle.
  - IDLE with len=3 gives 3 TCK pulses with tms_o=0.
- Reset during the SHIFT state of a 32-bit DR shift: the next cycle shows tck_o=0, tms_o=1, trst_no=0, rsp_valid_o=0. A subsequent TAP_RESET then completes normally.
